// File: rtl/frame_buf_pkg.sv
// Shared constants for the frame readout path: FSM encoding and geometry.
// Optional MCU_ORDER_EN build switches the pixel walk to 8x8 block order.
package frame_buf_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_HI = 3'd1;
  localparam logic [2:0] S_RD_LO = 3'd2;
  localparam logic [2:0] S_RD_WT = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  localparam int DEF_H_RES     = 160;
  localparam int DEF_TOTAL_ROW = 120;
  localparam int BYTES_PER_PIX = 2;
  localparam int MCU_DIM       = 8;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_readout_if.sv
// Buffer read port plus RGB565 valid/ready pixel stream.
// Shared by both MCU_ORDER_EN and raster builds.
interface frame_readout_if #(
  parameter int BUFF_BITS = 16
);
  logic                 rd_en;
  logic [BUFF_BITS-1:0] rd_addr;
  logic [7:0]           rd_data;
  logic [15:0]          pix_data;
  logic                 pix_valid;
  logic                 pix_ready;
  logic                 pix_sol;
  logic                 pix_eof;

  modport master (
    output rd_en, rd_addr,
    output pix_data, pix_valid, pix_sol, pix_eof,
    input  rd_data, pix_ready
  );

  modport slave (
    input  rd_en, rd_addr,
    input  pix_data, pix_valid, pix_sol, pix_eof,
    output rd_data, pix_ready
  );
endinterface

// File: rtl/frame_addr_gen.sv
// Pixel coordinate walker: raster by default, 8x8 blocks with MCU_ORDER_EN.
// Emits the linear pixel index plus first/last markers for the current pixel.
module frame_addr_gen
  import frame_buf_pkg::*;
#(
  parameter int H_RES     = DEF_H_RES,
  parameter int TOTAL_ROW = DEF_TOTAL_ROW,
  parameter int AW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [AW-1:0] idx,
  output logic          first,
  output logic          last
);

`ifdef MCU_ORDER_EN
  localparam int BXN = H_RES / MCU_DIM;
  localparam int BYN = TOTAL_ROW / MCU_DIM;
  localparam int BXW = cw(BXN);
  localparam int BYW = cw(BYN);
  localparam int MW  = $clog2(MCU_DIM);

  if ((H_RES % MCU_DIM) != 0 || (TOTAL_ROW % MCU_DIM) != 0) begin : g_bad_geom
    $error("frame_addr_gen: H_RES and TOTAL_ROW must be multiples of 8");
  end

  logic [MW-1:0]  x;
  logic [MW-1:0]  y;
  logic [BXW-1:0] bx;
  logic [BYW-1:0] by;

  logic x_end, y_end, bx_end, by_end;

  assign x_end  = (x == MW'(MCU_DIM - 1));
  assign y_end  = (y == MW'(MCU_DIM - 1));
  assign bx_end = (bx == BXW'(BXN - 1));
  assign by_end = (by == BYW'(BYN - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      x  <= '0;
      y  <= '0;
      bx <= '0;
      by <= '0;
    end else if (advance) begin
      x <= x_end ? '0 : x + 1'b1;
      if (x_end) begin
        y <= y_end ? '0 : y + 1'b1;
        if (y_end) begin
          bx <= bx_end ? '0 : bx + 1'b1;
          if (bx_end)
            by <= by_end ? '0 : by + 1'b1;
        end
      end
    end
  end

  assign idx = (AW'(by) * AW'(MCU_DIM) + AW'(y)) * AW'(H_RES)
             + AW'(bx) * AW'(MCU_DIM) + AW'(x);
  assign first = (x == '0) && (y == '0);
  assign last  = x_end && y_end && bx_end && by_end;
`else
  localparam int CW = cw(H_RES);
  localparam int RW = cw(TOTAL_ROW);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic col_end, row_end;

  assign col_end = (col == CW'(H_RES - 1));
  assign row_end = (row == RW'(TOTAL_ROW - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      col <= col_end ? '0 : col + 1'b1;
      if (col_end)
        row <= row_end ? '0 : row + 1'b1;
    end
  end

  assign idx   = AW'(row) * AW'(H_RES) + AW'(col);
  assign first = (col == '0);
  assign last  = col_end && row_end;
`endif

endmodule

// File: rtl/frame_readout.sv
// Streams a captured frame out of the byte buffer as RGB565 pixels.
// Pixel order is raster unless MCU_ORDER_EN is defined (8x8 blocks).
module frame_readout
  import frame_buf_pkg::*;
#(
  parameter int H_RES     = DEF_H_RES,
  parameter int TOTAL_ROW = DEF_TOTAL_ROW,
  parameter int BUFF_BITS = 16,
  parameter int ADDR_BASE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_ready,
  input  logic            start,
  output logic            busy,
  output logic            done,
  frame_readout_if.master bus
);

  logic [2:0]           state;
  logic [7:0]           hi;
  logic [15:0]          data_q;
  logic                 valid_q;
  logic                 sol_q;
  logic                 eof_q;
  logic [BUFF_BITS-1:0] idx;
  logic [BUFF_BITS-1:0] pix_addr;
  logic                 first;
  logic                 last;
  logic                 clear;
  logic                 advance;

  assign clear   = (state == S_IDLE);
  assign advance = (state == S_OUT) && bus.pix_ready;

  frame_addr_gen #(
    .H_RES    (H_RES),
    .TOTAL_ROW(TOTAL_ROW),
    .AW       (BUFF_BITS)
  ) u_addr (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .advance(advance),
    .idx    (idx),
    .first  (first),
    .last   (last)
  );

  assign pix_addr = BUFF_BITS'(ADDR_BASE)
                  + BUFF_BITS'(BYTES_PER_PIX) * idx;

  always_comb begin
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    unique case (1'b1)
      (state == S_RD_HI): begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = pix_addr;
      end
      (state == S_RD_LO): begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = pix_addr + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        // done still high means the pulse cycle: a start here is dropped
        S_IDLE: begin
          if (start && frame_ready && !done) begin
            state <= S_RD_HI;
            busy  <= 1'b1;
          end
        end
        S_RD_HI: state <= S_RD_LO;
        S_RD_LO: begin
          hi    <= bus.rd_data;
          state <= S_RD_WT;
        end
        S_RD_WT: begin
          data_q  <= {hi, bus.rd_data};
          valid_q <= 1'b1;
          sol_q   <= first;
          eof_q   <= last;
          state   <= S_OUT;
        end
        S_OUT: begin
          if (bus.pix_ready) begin
            valid_q <= 1'b0;
            sol_q   <= 1'b0;
            eof_q   <= 1'b0;
            if (eof_q) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_RD_HI;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.pix_data  = data_q;
  assign bus.pix_valid = valid_q;
  assign bus.pix_sol   = sol_q;
  assign bus.pix_eof   = eof_q;

endmodule

// File: tb/tb_frame_readout.sv
// Directed bench for frame_readout; buffer byte k holds value k.
// Build with MCU_ORDER_EN to exercise the 16x8 block-order geometry.
module tb_frame_readout;

`ifdef MCU_ORDER_EN
  localparam int HR = 16;
  localparam int TR = 8;
`else
  localparam int HR = 4;
  localparam int TR = 2;
`endif
  localparam int NPIX = HR * TR;
  localparam int BB   = 16;

  logic clk = 1'b0;
  logic rst;
  logic frame_ready;
  logic start;
  logic busy;
  logic done;

  int total = 0;
  int bad   = 0;

  frame_readout_if #(.BUFF_BITS(BB)) bus ();

  frame_readout #(
    .H_RES    (HR),
    .TOTAL_ROW(TR),
    .BUFF_BITS(BB),
    .ADDR_BASE(0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_ready(frame_ready),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.rd_en)
      bus.rd_data <= bus.rd_addr[7:0];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_idx(input int p);
`ifdef MCU_ORDER_EN
    int blk, w;
    blk = p / 64;
    w   = p % 64;
    return ((blk / (HR / 8)) * 8 + w / 8) * HR
         + (blk % (HR / 8)) * 8 + w % 8;
`else
    return p;
`endif
  endfunction

  function automatic logic exp_sol(input int p);
`ifdef MCU_ORDER_EN
    return (p % 64) == 0;
`else
    return (p % HR) == 0;
`endif
  endfunction

  function automatic logic [15:0] exp_pix(input int p);
    logic [7:0] a;
    a = 8'(2 * exp_idx(p));
    return {a, a + 8'd1};
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_rden"}, bus.rd_en, 1'b0);
    check({tag, "_valid"}, bus.pix_valid, 1'b0);
  endtask

  task automatic run_frame(input int stall_pix,
                           input bit poke,
                           input int abort_at);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_on", busy, 1'b1);
    for (int p = 0; p < NPIX; p++) begin
      n = 0;
      while (!bus.pix_valid && n < 16) begin
        tick();
        n++;
      end
      check("latency", n, 3);
      if (!bus.pix_valid) return;
      check("data", bus.pix_data, exp_pix(p));
      check("sol", bus.pix_sol, exp_sol(p));
      check("eof", bus.pix_eof, p == NPIX - 1);
      check("rden_out", bus.rd_en, 1'b0);
      if (p == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_quiet("abort");
        check("abort_data", bus.pix_data, 16'h0);
        check("abort_sol", bus.pix_sol, 1'b0);
        check("abort_eof", bus.pix_eof, 1'b0);
        repeat (6) begin
          tick();
          check("abort_nodone", done, 1'b0);
        end
        return;
      end
      if (p == stall_pix) begin
        bus.pix_ready = 1'b0;
        repeat (5) begin
          tick();
          check("stall_valid", bus.pix_valid, 1'b1);
          check("stall_data", bus.pix_data, exp_pix(p));
          check("stall_rden", bus.rd_en, 1'b0);
        end
        bus.pix_ready = 1'b1;
      end
      if (poke && p == 1)
        start = 1'b1;
      tick();
      start = 1'b0;
    end
    check("done", done, 1'b1);
    check("busy_off", busy, 1'b0);
    tick();
    check("done_pulse", done, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    frame_ready   = 1'b0;
    start         = 1'b0;
    bus.pix_ready = 1'b1;
    repeat (3) tick();
    check_quiet("reset");
    check("reset_data", bus.pix_data, 16'h0);
    check("reset_sol", bus.pix_sol, 1'b0);
    check("reset_eof", bus.pix_eof, 1'b0);
    rst = 1'b0;
    tick();

    frame_ready = 1'b1;
    run_frame(-1, 1'b0, -1);

    // back-to-back: start lands one clk after the done pulse
    run_frame(-1, 1'b0, -1);

    repeat (2) tick();
    run_frame(2, 1'b0, -1);

    frame_ready = 1'b0;
    start       = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) begin
      check_quiet("no_frame");
      tick();
    end
    frame_ready = 1'b1;
    run_frame(-1, 1'b1, -1);

    run_frame(-1, 1'b0, 3);
    run_frame(-1, 1'b0, -1);

`ifdef MCU_ORDER_EN
    check("mcu_pix8", exp_pix(8), 16'h2021);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
